// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR datapath.
//   DATA_WIDTH : sample/coefficient width (signed two's complement, Q16.16)
//   Q_FORMAT   : fractional bits (informational, no arithmetic depends on it)
//   NUM_REGS   : number of taps
//   ACC_WIDTH  : accumulator width the downstream mac needs for a full-precision sum
package fir_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned Q_FORMAT   = 16;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(NUM_REGS);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef sample_t [0:NUM_REGS-1] tap_array_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } loader_state_e;

  // Address width for an n-entry file; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_coef_regfile.sv
// Coefficient register file: one synchronous write port, full parallel read-out.
//   clk, rst_n : clock, asynchronous active-low reset (clears every entry)
//   i_wr_en    : write i_data into entry i_addr on the rising edge
//   i_addr     : entry index; indices >= NUM_REGS are dropped
//   i_data     : value to write
//   o_coefs    : all entries, [0] is coefficient 0
module fir_coef_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_wr_en,
  input  logic [ADDR_W-1:0]                    i_addr,
  input  logic [DATA_WIDTH-1:0]                i_data,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  o_coefs
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_coefs;
  logic [31:0]                         w_addr_ext;

  assign w_addr_ext = 32'(i_addr);

  // Per-entry address match: an out-of-range index simply matches nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coefs <= '0;
    end else if (i_wr_en) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (w_addr_ext == 32'(i)) begin
          r_coefs[i] <= i_data;
        end
      end
    end
  end

  assign o_coefs = r_coefs;

endmodule

// File: rtl/fir_tap_loader.sv
// FIR input stage: accepts Q16.16 samples over valid/ready, shifts them into a
// NUM_REGS-deep tap delay line and hosts the coefficient register file.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sampleIn     : new sample;  sampleValid / sampleReady handshake
//   coefWrEn     : write coefData into coefs[coefAddr] (stalls samples that cycle)
//   flush        : clear tap history and restart the fill (coefficients kept)
//   pDataOut     : taps, [0] newest .. [NUM_REGS-1] oldest
//   coefsOut     : coefficient register file, straight to the mac
//   tapsValid    : one-cycle pulse, taps freshly updated and usable
//   primed       : NUM_REGS samples accepted since reset/flush
module fir_tap_loader #(
  parameter int unsigned DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int unsigned Q_FORMAT   = fir_pkg::Q_FORMAT,
  parameter int unsigned NUM_REGS   = fir_pkg::NUM_REGS,
  parameter bit          ZERO_PAD   = 1'b0,
  localparam int unsigned ADDR_W    = fir_pkg::addr_width(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATA_WIDTH-1:0]                sampleIn,
  input  logic                                 sampleValid,
  output logic                                 sampleReady,
  input  logic                                 coefWrEn,
  input  logic [ADDR_W-1:0]                    coefAddr,
  input  logic [DATA_WIDTH-1:0]                coefData,
  input  logic                                 flush,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  pDataOut,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  coefsOut,
  output logic                                 tapsValid,
  output logic                                 primed
);

  import fir_pkg::*;

  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_REGS);

  // Elaboration-time sanity checks on the parameter set.
  if (NUM_REGS < 2) begin : g_bad_num_regs
    $error("fir_tap_loader: NUM_REGS must be at least 2");
  end
  if (Q_FORMAT >= DATA_WIDTH) begin : g_bad_q_format
    $error("fir_tap_loader: Q_FORMAT must leave at least one integer bit");
  end

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_taps;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_taps_next;
  logic [CNT_W-1:0]                    r_count;
  logic [CNT_W-1:0]                    w_count_next;
  loader_state_e                       r_state;
  loader_state_e                       w_state_next;
  logic                                r_taps_valid;
  logic                                w_taps_valid_next;
  logic                                r_primed;
  logic                                w_primed_next;
  logic                                w_accept;

  // Coefficient writes and flushes own the cycle, so samples stall instead of
  // racing them. Held low during reset so nothing upstream sees a phantom slot.
  assign sampleReady = rst_n && !coefWrEn && !flush;
  assign w_accept    = sampleValid && sampleReady;

  always_comb begin
    w_taps_next       = r_taps;
    w_count_next      = r_count;
    w_state_next      = r_state;
    w_primed_next     = r_primed;
    w_taps_valid_next = 1'b0;

    if (flush) begin
      w_taps_next   = '0;
      w_count_next  = '0;
      w_state_next  = FILL;
      w_primed_next = 1'b0;
    end else if (w_accept) begin
      w_taps_next[0] = sampleIn;
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        w_taps_next[i] = r_taps[i-1];
      end

      // Count only while filling; once in RUN it stays pinned at NUM_REGS.
      if (r_state == FILL) begin
        w_count_next = r_count + 1'b1;
        if (w_count_next == FULL_CNT) begin
          w_state_next  = RUN;
          w_primed_next = 1'b1;
        end
      end

      w_taps_valid_next = ZERO_PAD || (w_state_next == RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taps       <= '0;
      r_count      <= '0;
      r_state      <= FILL;
      r_taps_valid <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_taps       <= w_taps_next;
      r_count      <= w_count_next;
      r_state      <= w_state_next;
      r_taps_valid <= w_taps_valid_next;
      r_primed     <= w_primed_next;
    end
  end

  fir_coef_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_W     (ADDR_W)
  ) u_coef_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr_en (coefWrEn),
    .i_addr  (coefAddr),
    .i_data  (coefData),
    .o_coefs (coefsOut)
  );

  assign pDataOut  = r_taps;
  assign tapsValid = r_taps_valid;
  assign primed    = r_primed;

endmodule
